// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-cache request port between the load queue and the
// store drain. Each cycle it grants one requester. An in-order tracking FIFO
// records who owns every accepted request, so that each cache response can be
// routed back to the right side. Loads that were in flight when a backend
// flush arrived are marked squashed, and their responses are dropped.

module dmem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        backend_flush,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_rmask,
    output logic [31:0] ld_rdata,
    output logic        ld_resp,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_wmask,
    input  logic [31:0] st_wdata,
    input  logic        st_urgent,
    output logic        st_resp,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Tracking FIFO storage: one owner bit and one squash bit per slot
    logic [MAX_OUTSTANDING-1:0] r_isStore;
    logic [MAX_OUTSTANDING-1:0] r_squash;
    logic [PW-1:0]              r_wrPtr;
    logic [PW-1:0]              r_rdPtr;
    logic [CW-1:0]              r_count;
    logic [SW-1:0]              r_starveCnt;

    logic                       w_fifoEmpty;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_canIssue;
    logic                       w_ldValidEff;
    logic                       w_grantSt;
    logic                       w_grantLd;
    logic                       w_headIsStore;
    logic                       w_headSquash;
    logic [MAX_OUTSTANDING-1:0] w_isStoreNext;
    logic [MAX_OUTSTANDING-1:0] w_squashNext;

    // Grant selection: a store wins when urgent, starved or unopposed
    always_comb begin
        w_fifoEmpty  = (r_count == '0);
        w_pop        = dmem_resp && !w_fifoEmpty;
        w_canIssue   = (r_count < MAX_CNT) || dmem_resp;
        w_ldValidEff = ld_valid && !backend_flush;
        w_grantSt    = w_canIssue && st_valid &&
                       (st_urgent || (r_starveCnt >= STARVE_MAX) || !w_ldValidEff);
        w_grantLd    = w_canIssue && !w_grantSt && w_ldValidEff;
        w_push       = (w_grantSt || w_grantLd) && dmem_ready;
    end

    // Request-side outputs: payload of the granted side, zero otherwise
    always_comb begin
        dmem_valid = w_grantSt || w_grantLd;
        ld_ready   = w_grantLd && dmem_ready;
        st_ready   = w_grantSt && dmem_ready;
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        if (w_grantSt) begin
            dmem_addr  = st_addr;
            dmem_wmask = st_wmask;
            dmem_wdata = st_wdata;
        end else if (w_grantLd) begin
            dmem_addr  = ld_addr;
            dmem_rmask = ld_rmask;
        end
    end

    // Response routing from the FIFO head; squashed loads vanish silently
    always_comb begin
        w_headIsStore = r_isStore[r_rdPtr];
        w_headSquash  = r_squash[r_rdPtr];
        st_resp       = w_pop && w_headIsStore;
        ld_resp       = w_pop && !w_headIsStore && !w_headSquash;
        ld_rdata      = ld_resp ? dmem_rdata : '0;
    end

    // Next slot contents: a flush marks every load slot, a push rewrites its slot
    always_comb begin
        w_isStoreNext = r_isStore;
        w_squashNext  = r_squash;
        if (backend_flush) begin
            w_squashNext = r_squash | ~r_isStore;
        end
        if (w_push) begin
            w_isStoreNext[r_wrPtr] = w_grantSt;
            w_squashNext[r_wrPtr]  = 1'b0;
        end
    end

    // Tracking FIFO pointers, occupancy and slot contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_isStore <= '0;
            r_squash  <= '0;
        end else begin
            r_isStore <= w_isStoreNext;
            r_squash  <= w_squashNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Store starvation counter: counts cycles a waiting store goes unaccepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= '0;
        end else if (!st_valid || st_ready) begin
            r_starveCnt <= '0;
        end else if (r_starveCnt < STARVE_MAX) begin
            r_starveCnt <= r_starveCnt + SW'(1);
        end
    end

    // A response with nothing outstanding means the cache broke the protocol
    assert property (@(posedge clk) disable iff (rst) !(dmem_resp && w_fifoEmpty));

endmodule
